// File: rtl/half_subtractor_unit.sv
// Lane-parallel half subtractor with registered outputs and a saturating borrow-event counter.
// Latency: 1 cycle from an accepted input (in_valid=1) to out_valid/diff/borrow.
// Backpressure: none; every accepted input yields exactly one out_valid cycle.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, a, b      qualified minuend/subtrahend, one bit per lane
//   out_valid           diff/borrow hold a freshly registered result
//   diff, borrow        per-lane a XOR b, (NOT a) AND b
//   borrow_cnt, cnt_clr saturating count of accepted cycles with any borrow; sync clear
module half_subtractor_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic [CNT_W-1:0] borrow_cnt,
  input  logic             cnt_clr
);

  logic             valid_q;
  logic [WIDTH-1:0] diff_d,   diff_q;
  logic [WIDTH-1:0] borrow_d, borrow_q;
  logic [CNT_W-1:0] cnt_d,    cnt_q;

  // Lanes are independent: no borrow-in, so each bit is a pure 2-input function.
  always_comb begin
    diff_d   = a ^ b;
    borrow_d = ~a & b;
  end

  // Clear wins over increment; the increment is gated by in_valid so that
  // garbage on a/b during idle cycles can never bump the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (in_valid && (|borrow_d) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= in_valid;
      cnt_q   <= cnt_d;
      // Result registers only load on accepted inputs; they hold across gaps.
      if (in_valid) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign diff       = diff_q;
  assign borrow     = borrow_q;
  assign borrow_cnt = cnt_q;

endmodule

// File: tb/tb_half_subtractor_unit.sv
module tb_half_subtractor_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance 1: WIDTH=1, CNT_W=8
  logic       v1 = 1'b0, c1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ov1;
  logic [0:0] d1, br1;
  logic [7:0] n1;

  // Instance 4: WIDTH=4, CNT_W=8
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ov4;
  logic [3:0] d4, br4;
  logic [7:0] n4;

  // Instance 2: WIDTH=1, CNT_W=2
  logic       v2 = 1'b0, c2 = 1'b0;
  logic [0:0] a2 = '0, b2 = '0;
  logic       ov2;
  logic [0:0] d2, br2;
  logic [1:0] n2;

  half_subtractor_unit #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .out_valid(ov1), .diff(d1), .borrow(br1), .borrow_cnt(n1), .cnt_clr(c1));

  half_subtractor_unit #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4),
    .out_valid(ov4), .diff(d4), .borrow(br4), .borrow_cnt(n4), .cnt_clr(c4));

  half_subtractor_unit #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2),
    .out_valid(ov2), .diff(d2), .borrow(br2), .borrow_cnt(n2), .cnt_clr(c2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic ov, input logic d, input logic br, input logic [7:0] n);
    chk({tag, ".valid"},  {31'd0, ov1}, {31'd0, ov});
    chk({tag, ".diff"},   {31'd0, d1},  {31'd0, d});
    chk({tag, ".borrow"}, {31'd0, br1}, {31'd0, br});
    chk({tag, ".cnt"},    {24'd0, n1},  {24'd0, n});
  endtask

  task automatic chk4(input string tag, input logic ov, input logic [3:0] d, input logic [3:0] br, input logic [7:0] n);
    chk({tag, ".valid"},  {31'd0, ov4}, {31'd0, ov});
    chk({tag, ".diff"},   {28'd0, d4},  {28'd0, d});
    chk({tag, ".borrow"}, {28'd0, br4}, {28'd0, br});
    chk({tag, ".cnt"},    {24'd0, n4},  {24'd0, n});
  endtask

  task automatic chk2(input string tag, input logic ov, input logic d, input logic br, input logic [1:0] n);
    chk({tag, ".valid"},  {31'd0, ov2}, {31'd0, ov});
    chk({tag, ".diff"},   {31'd0, d2},  {31'd0, d});
    chk({tag, ".borrow"}, {31'd0, br2}, {31'd0, br});
    chk({tag, ".cnt"},    {30'd0, n2},  {30'd0, n});
  endtask

  initial begin
    // Reset held: everything zero, no clock dependence needed.
    #3;
    chk1("rst_u1", 1'b0, 1'b0, 1'b0, 8'd0);
    chk4("rst_u4", 1'b0, 4'h0, 4'h0, 8'd0);
    chk2("rst_u2", 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk1("post_rst_u1", 1'b0, 1'b0, 1'b0, 8'd0);

    // WIDTH=1 truth table, one cycle latency.
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
    step(); chk1("tt00", 1'b1, 1'b0, 1'b0, 8'd0);
    a1 = 1'b0; b1 = 1'b1;
    step(); chk1("tt01", 1'b1, 1'b1, 1'b1, 8'd1);
    a1 = 1'b1; b1 = 1'b0;
    step(); chk1("tt10", 1'b1, 1'b1, 1'b0, 8'd1);
    a1 = 1'b1; b1 = 1'b1;
    step(); chk1("tt11", 1'b1, 1'b0, 1'b0, 8'd1);
    v1 = 1'b0;

    // WIDTH=4 mixed lanes: no inter-lane borrow.
    v4 = 1'b1; a4 = 4'b0101; b4 = 4'b0011;
    step(); chk4("w4_mix", 1'b1, 4'b0110, 4'b0010, 8'd1);

    // Valid pulses 1,0,1; results hold through the gap even with new a/b.
    a4 = 4'b1100; b4 = 4'b0000;
    step(); chk4("gap_v1", 1'b1, 4'b1100, 4'b0000, 8'd1);
    v4 = 1'b0; a4 = 4'b0001; b4 = 4'b1111;
    step(); chk4("gap_v0", 1'b0, 4'b1100, 4'b0000, 8'd1);
    v4 = 1'b1; a4 = 4'b0000; b4 = 4'b0001;
    step(); chk4("gap_v1b", 1'b1, 4'b0001, 4'b0001, 8'd2);
    v4 = 1'b0;

    // CNT_W=2 saturation and clear priority.
    v2 = 1'b1; a2 = 1'b0; b2 = 1'b1;
    step(); chk2("sat1", 1'b1, 1'b1, 1'b1, 2'd1);
    step(); chk2("sat2", 1'b1, 1'b1, 1'b1, 2'd2);
    step(); chk2("sat3", 1'b1, 1'b1, 1'b1, 2'd3);
    step(); chk2("sat4", 1'b1, 1'b1, 1'b1, 2'd3);
    step(); chk2("sat5", 1'b1, 1'b1, 1'b1, 2'd3);
    c2 = 1'b1;
    step(); chk2("clr_pri", 1'b1, 1'b1, 1'b1, 2'd0);
    c2 = 1'b0;
    step(); chk2("after_clr", 1'b1, 1'b1, 1'b1, 2'd1);
    v2 = 1'b0;
    // Idle cycle with a borrow pattern on a/b must not count.
    step(); chk2("idle_nocnt", 1'b0, 1'b1, 1'b1, 2'd1);

    // Mid-cycle asynchronous reset.
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    step(); chk1("pre_arst", 1'b1, 1'b1, 1'b1, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_u1", 1'b0, 1'b0, 1'b0, 8'd0);
    chk4("arst_u4", 1'b0, 4'h0, 4'h0, 8'd0);
    chk2("arst_u2", 1'b0, 1'b0, 1'b0, 2'd0);
    v1 = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step(); chk1("rel_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    step(); chk1("rel_first", 1'b1, 1'b1, 1'b0, 8'd0);
    v1 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
